// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the IF stage: architectural constants, the fetch
// FSM encoding and small address helpers.
package rv32_pkg;

  localparam int unsigned RV32_XLEN = 32;
  localparam logic [RV32_XLEN-1:0] RV32_NOP = 32'h0000_0013;

  // mcause encoding reported downstream for a misaligned fetch target.
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [RV32_XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [RV32_XLEN-1:0] pc_next(input logic [RV32_XLEN-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side
// valid/ready entry channel.
interface if_fetch_unit_if;

    logic                               imem_en;
    logic [rv32_pkg::RV32_XLEN-1:0]     imem_addr;
    logic [rv32_pkg::RV32_XLEN-1:0]     imem_rdata;
    logic                               if_valid;
    logic                               if_ready;
    logic [rv32_pkg::RV32_XLEN-1:0]     if_pc;
    logic [rv32_pkg::RV32_XLEN-1:0]     if_instr;
    logic                               if_fault;

    modport master (
        output imem_en, imem_addr, if_valid, if_pc, if_instr, if_fault,
        input  imem_rdata, if_ready
    );

    modport slave (
        input  imem_en, imem_addr, if_valid, if_pc, if_instr, if_fault,
        output imem_rdata, if_ready
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: drives a sync-address instruction memory and
// presents {pc, instr} to decode, with stall, redirect and misaligned-fault handling.
module if_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [RV32_XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [RV32_XLEN-1:0] NOP_WORD = RV32_NOP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [RV32_XLEN-1:0] redirect_pc,
    if_fetch_unit_if.master      bus,
    output logic [RV32_XLEN-1:0] fetch_count
);

    fetch_state_e         state_q, state_d;
    logic [RV32_XLEN-1:0] pc_q, pc_d;
    logic [RV32_XLEN-1:0] req_pc_q, req_pc_d;
    logic                 req_valid_q, req_valid_d;
    logic                 fault_q, fault_d;
    logic [RV32_XLEN-1:0] count_q, count_d;

    logic                 advance;
    logic                 accept;
    logic                 issue;
    logic [RV32_XLEN-1:0] issue_addr;

    // req_pc_q/req_valid_q mirror what the memory address register holds, so the
    // presented entry is purely a function of registered state and imem_rdata.
    assign bus.if_valid = req_valid_q & ~redirect_valid;
    assign bus.if_pc    = req_pc_q;
    assign bus.if_instr = fault_q ? NOP_WORD : bus.imem_rdata;
    assign bus.if_fault = fault_q & req_valid_q;

    assign accept  = bus.if_valid & bus.if_ready;
    assign advance = (~req_valid_q | bus.if_ready) & fetch_en
                     & (state_q == FETCH_RUN) & ~redirect_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        fault_d     = fault_q;
        issue       = 1'b0;
        issue_addr  = pc_q;

        if (redirect_valid) begin
            if (!is_word_aligned(redirect_pc)) begin
                // No memory access: the fault entry carries the bad target as its pc.
                state_d     = FETCH_FAULT;
                req_valid_d = 1'b1;
                fault_d     = 1'b1;
                req_pc_d    = redirect_pc;
            end else if (fetch_en) begin
                issue       = 1'b1;
                issue_addr  = redirect_pc;
                req_pc_d    = redirect_pc;
                req_valid_d = 1'b1;
                pc_d        = pc_next(redirect_pc);
                fault_d     = 1'b0;
                state_d     = FETCH_RUN;
            end else begin
                pc_d        = redirect_pc;
                req_valid_d = 1'b0;
                fault_d     = 1'b0;
                state_d     = FETCH_RUN;
            end
        end else if (advance) begin
            issue       = 1'b1;
            issue_addr  = pc_q;
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_next(pc_q);
        end else if (accept) begin
            req_valid_d = 1'b0;
        end
    end

    // Holding imem_en low during a stall freezes the memory output, which keeps
    // if_instr stable without a local instruction buffer.
    assign bus.imem_en   = issue & ~rst;
    assign bus.imem_addr = bus.imem_en ? issue_addr : pc_q;

    assign count_d     = count_q + {{(RV32_XLEN-1){1'b0}}, (accept & ~fault_q)};
    assign fetch_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_RUN;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table with a behavioural
// sync-address memory, plus a hand-written asynchronous reset sequence.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    if_fetch_unit_if mif ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (mif),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory model: word i holds A000_0000 + i; address captured on enabled edges.
    logic [31:0] mem [256];
    logic [7:0]  maddr_q = 8'd0;
    always @(posedge clk) if (mif.imem_en) maddr_q <= mif.imem_addr[9:2];
    assign mif.imem_rdata = mem[maddr_q];

    typedef struct {
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        en;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flt;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] A(input int n);
        return 32'hA000_0000 + n;
    endfunction

    task automatic add(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic en, input logic [31:0] addr, input logic vld,
                       input logic [31:0] pc, input logic [31:0] instr, input logic flt,
                       input logic [31:0] cnt);
        vec_t v;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.en = en; v.addr = addr;
        v.vld = vld; v.pc = pc; v.instr = instr; v.flt = flt; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = A(i);

        //    fe rv rpc        rdy  en addr        vld pc          instr         flt cnt
        add(1, 0, 32'h0,   1,   1, 32'h000, 0, 32'h000, 32'h0,        0, 0);   // 0 first issue
        add(1, 0, 32'h0,   1,   1, 32'h004, 1, 32'h000, A(0),         0, 0);
        add(1, 0, 32'h0,   1,   1, 32'h008, 1, 32'h004, A(1),         0, 1);
        add(1, 0, 32'h0,   1,   1, 32'h00C, 1, 32'h008, A(2),         0, 2);
        for (int k = 0; k < 4; k++)                                               // 4..7 stall
            add(1, 0, 32'h0, 0, 0, 32'h010, 1, 32'h00C, A(3),         0, 3);
        add(1, 0, 32'h0,   1,   1, 32'h010, 1, 32'h00C, A(3),         0, 3);
        add(1, 0, 32'h0,   1,   1, 32'h014, 1, 32'h010, A(4),         0, 4);
        add(1, 1, 32'h100, 1,   1, 32'h100, 0, 32'h014, 32'h0,        0, 5);   // 10 redirect
        add(1, 0, 32'h0,   1,   1, 32'h104, 1, 32'h100, A(32'h40),    0, 5);
        add(1, 0, 32'h0,   1,   1, 32'h108, 1, 32'h104, A(32'h41),    0, 6);
        add(1, 0, 32'h0,   0,   0, 32'h10C, 1, 32'h108, A(32'h42),    0, 7);   // 13 stall
        add(1, 1, 32'h40,  0,   1, 32'h040, 0, 32'h108, 32'h0,        0, 7);   // 14 redirect in stall
        add(1, 0, 32'h0,   0,   0, 32'h044, 1, 32'h040, A(32'h10),    0, 7);
        add(1, 0, 32'h0,   1,   1, 32'h044, 1, 32'h040, A(32'h10),    0, 7);
        add(1, 1, 32'h102, 1,   0, 32'h048, 0, 32'h044, 32'h0,        0, 8);   // 17 misaligned
        add(1, 0, 32'h0,   0,   0, 32'h048, 1, 32'h102, 32'h13,       1, 8);
        add(1, 0, 32'h0,   1,   0, 32'h048, 1, 32'h102, 32'h13,       1, 8);
        add(1, 0, 32'h0,   1,   0, 32'h048, 0, 32'h102, 32'h0,        0, 8);
        add(1, 0, 32'h0,   1,   0, 32'h048, 0, 32'h102, 32'h0,        0, 8);
        add(1, 1, 32'h106, 1,   0, 32'h048, 0, 32'h102, 32'h0,        0, 8);   // 22 fault replace
        add(1, 0, 32'h0,   1,   0, 32'h048, 1, 32'h106, 32'h13,       1, 8);
        add(1, 1, 32'h200, 1,   1, 32'h200, 0, 32'h106, 32'h0,        0, 8);   // 24 resume
        add(1, 0, 32'h0,   1,   1, 32'h204, 1, 32'h200, A(32'h80),    0, 8);
        add(1, 0, 32'h0,   1,   1, 32'h208, 1, 32'h204, A(32'h81),    0, 9);
        add(0, 0, 32'h0,   1,   0, 32'h20C, 1, 32'h208, A(32'h82),    0, 10);  // 27 disable
        add(0, 0, 32'h0,   1,   0, 32'h20C, 0, 32'h208, 32'h0,        0, 11);
        add(0, 1, 32'h300, 1,   0, 32'h20C, 0, 32'h208, 32'h0,        0, 11);  // 29 redirect, disabled
        add(0, 0, 32'h0,   1,   0, 32'h300, 0, 32'h208, 32'h0,        0, 11);
        add(1, 0, 32'h0,   1,   1, 32'h300, 0, 32'h208, 32'h0,        0, 11);
        add(1, 0, 32'h0,   1,   1, 32'h304, 1, 32'h300, A(32'hC0),    0, 11);

        rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mif.if_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset if_valid", {31'b0, mif.if_valid}, 32'd0);
        check("reset imem_en", {31'b0, mif.imem_en}, 32'd0);
        check("reset if_fault", {31'b0, mif.if_fault}, 32'd0);
        check("reset fetch_count", fetch_count, 32'd0);

        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            fetch_en = vecs[i].fe; redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc; mif.if_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d imem_en", i), {31'b0, mif.imem_en}, {31'b0, vecs[i].en});
            check($sformatf("v%0d imem_addr", i), mif.imem_addr, vecs[i].addr);
            check($sformatf("v%0d if_valid", i), {31'b0, mif.if_valid}, {31'b0, vecs[i].vld});
            check($sformatf("v%0d if_pc", i), mif.if_pc, vecs[i].pc);
            check($sformatf("v%0d if_fault", i), {31'b0, mif.if_fault}, {31'b0, vecs[i].flt});
            check($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].cnt);
            if (vecs[i].vld)
                check($sformatf("v%0d if_instr", i), mif.if_instr, vecs[i].instr);
        end

        // Asynchronous reset mid-stream: outputs must drop before the next edge.
        @(posedge clk); #1;
        fetch_en = 1'b1; redirect_valid = 1'b0; mif.if_ready = 1'b1;
        #1;
        check("pre-reset if_valid", {31'b0, mif.if_valid}, 32'd1);
        check("pre-reset if_pc", mif.if_pc, 32'h304);
        #1; rst = 1'b1;
        #1;
        check("async rst if_valid", {31'b0, mif.if_valid}, 32'd0);
        check("async rst imem_en", {31'b0, mif.imem_en}, 32'd0);
        check("async rst fetch_count", fetch_count, 32'd0);
        check("async rst if_pc", mif.if_pc, 32'd0);
        @(posedge clk); #1;
        check("held rst imem_en", {31'b0, mif.imem_en}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        #1;
        check("post-rst imem_en", {31'b0, mif.imem_en}, 32'd1);
        check("post-rst imem_addr", mif.imem_addr, 32'h0);
        @(posedge clk); #2;
        check("post-rst if_valid", {31'b0, mif.if_valid}, 32'd1);
        check("post-rst if_pc", mif.if_pc, 32'h0);
        check("post-rst if_instr", mif.if_instr, A(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
